xor_checksum: RTL and testbench

Parametrised streaming XOR checksum engine: accumulates the bitwise XOR of a frame of WIDTH-bit words and either emits the checksum (generate mode) or checks that the frame, including its trailing check word, XORs to zero (check mode). It is the sequential, multi-bit successor to the single-bit XOR gate. It sits on a valid/ready byte or word stream ahead of framing logic.

---
 rtl/xor_checksum.sv | 108 ++++++++++
 tb/tb_xor_checksum.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_checksum.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : xor_checksum                                             |
// | Description : Streaming XOR checksum engine with generate/check modes, |
// |               valid/ready input and output handshakes.                 |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module xor_checksum #(
    parameter  int WIDTH   = 8,
    parameter  int MAX_LEN = 16,
    localparam int LW      = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [LW-1:0]    out_len,
    output logic             out_err,
    output logic             out_mode
);

    typedef enum logic [0:0] {
        ACC = 1'b0,
        OUT = 1'b1
    } state_t;

    localparam logic [LW-1:0] c_max_len = LW'(MAX_LEN);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_acc;
    logic [LW-1:0]    r_cnt;
    logic             r_ovf;
    logic             r_mode_q;

    logic             w_xfer;
    logic             w_first;
    logic [WIDTH-1:0] w_acc_next;
    logic [LW-1:0]    w_cnt_next;
    logic             w_ovf_next;
    logic             w_mode_eff;

    // Handshake flags decode straight from the state flop, so no path from out_ready.
    assign in_ready   = (r_state == ACC);
    assign out_valid  = (r_state == OUT);

    assign w_xfer     = in_valid && in_ready;
    assign w_first    = (r_cnt == '0);
    assign w_acc_next = r_acc ^ in_data;
    assign w_cnt_next = (r_cnt == c_max_len) ? r_cnt : r_cnt + 1'b1;
    assign w_ovf_next = r_ovf | (r_cnt == c_max_len);
    assign w_mode_eff = w_first ? mode : r_mode_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ACC: if (w_xfer && in_last) w_state_next = OUT;
            OUT: if (out_ready)         w_state_next = ACC;
            default:                    w_state_next = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
            r_mode_q <= 1'b0;
            out_sum  <= '0;
            out_len  <= '0;
            out_err  <= 1'b0;
            out_mode <= 1'b0;
        end else if (w_xfer) begin
            r_acc <= w_acc_next;
            r_cnt <= w_cnt_next;
            r_ovf <= w_ovf_next;
            if (w_first) begin
                r_mode_q <= mode;
            end
            if (in_last) begin
                out_sum  <= w_acc_next;
                out_len  <= w_cnt_next;
                out_mode <= w_mode_eff;
                out_err  <= w_ovf_next | (w_mode_eff && (w_acc_next != '0));
            end
        end else if ((r_state == OUT) && out_ready) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_xor_checksum.sv
`default_nettype none
// Testbench for xor_checksum: directed scenarios plus randomized frames
// compared against a frame-level reference model.
module tb_xor_checksum;

    localparam int W    = 8;
    localparam int MAXL = 4;
    localparam int LW   = $clog2(MAXL + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          mode;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic [LW-1:0] out_len;
    logic          out_err;
    logic          out_mode;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] fd [0:15];
    logic         fm [0:15];

    xor_checksum #(.WIDTH(W), .MAX_LEN(MAXL)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_len(out_len), .out_err(out_err), .out_mode(out_mode)
    );

    always #5 clk = ~clk;

    // Frame-level reference: XOR of all words, saturated count, mode of first word.
    function automatic void model(input int n, output logic [W-1:0] s,
                                  output logic [LW-1:0] l, output logic e, output logic m);
        s = '0;
        for (int i = 0; i < n; i++) s = s ^ fd[i];
        l = LW'((n > MAXL) ? MAXL : n);
        m = fm[0];
        e = (n > MAXL) || (m && (s != '0));
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready;
        int b = 0;
        while (!in_ready && b < 50) begin
            tick();
            b++;
        end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL in_ready_timeout: in_ready=%0b required 1", in_ready);
        end
    endtask

    task automatic drive_frame(input int n, input int max_gap);
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0; in_data = W'($urandom); in_last = 1'($urandom); mode = 1'($urandom);
                tick();
            end
            in_valid = 1'b1; in_data = fd[i]; in_last = (i == n - 1); mode = fm[i];
            wait_ready();
            tick();
        end
        in_valid = 1'b0; in_last = 1'b0; in_data = W'($urandom);
    endtask

    task automatic take_result(input int delay, output logic [W-1:0] s,
                               output logic [LW-1:0] l, output logic e, output logic m);
        int b = 0;
        while (!out_valid && b < 50) begin
            tick();
            b++;
        end
        if (!out_valid) begin
            checks++; failures++;
            $display("FAIL out_valid_timeout: out_valid=%0b required 1", out_valid);
        end
        s = out_sum; l = out_len; e = out_err; m = out_mode;
        repeat (delay) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; mode = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        checks++;
        if ({in_ready, out_valid, out_sum, out_len, out_err, out_mode} !== {1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset: rdy=%0b vld=%0b sum=%h len=%0d err=%0b mode=%0b required 1 0 00 0 0 0",
                     in_ready, out_valid, out_sum, out_len, out_err, out_mode);
        end
    endtask

    task automatic test_generate;
        fd[0] = 8'h12; fd[1] = 8'h34; fd[2] = 8'h56;
        fm[0] = 1'b0;  fm[1] = 1'b0;  fm[2] = 1'b0;
        out_ready = 1'b1;
        drive_frame(3, 0);
        checks++;
        if ({out_valid, in_ready, out_sum, out_len, out_err, out_mode} !== {1'b1, 1'b0, 8'h70, 3'd3, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL generate: vld=%0b rdy=%0b sum=%h len=%0d err=%0b mode=%0b required 1 0 70 3 0 0",
                     out_valid, in_ready, out_sum, out_len, out_err, out_mode);
        end
        tick();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL generate_pulse: vld=%0b rdy=%0b required 0 1", out_valid, in_ready);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_check;
        logic [W-1:0] s; logic [LW-1:0] l; logic e, m;
        fd[0] = 8'hA5; fd[1] = 8'h0F; fd[2] = 8'hAA;
        fm[0] = 1'b1;  fm[1] = 1'b1;  fm[2] = 1'b1;
        drive_frame(3, 0);
        take_result(0, s, l, e, m);
        checks++;
        if ({s, e, m} !== {8'h00, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL check_good: sum=%h err=%0b mode=%0b required 00 0 1", s, e, m);
        end
        fd[2] = 8'hAB;
        drive_frame(3, 0);
        take_result(0, s, l, e, m);
        checks++;
        if ({s, l, e} !== {8'h01, 3'd3, 1'b1}) begin
            failures++;
            $display("FAIL check_bad: sum=%h len=%0d err=%0b required 01 3 1", s, l, e);
        end
    endtask

    task automatic test_backpressure;
        logic [W-1:0] s; logic [LW-1:0] l; logic e, m;
        fd[0] = 8'hC3; fd[1] = 8'h3C; fm[0] = 1'b0; fm[1] = 1'b0;
        drive_frame(2, 0);
        in_valid = 1'b1; in_data = 8'h5A; in_last = 1'b1; mode = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({in_ready, out_valid, out_sum, out_len} !== {1'b0, 1'b1, 8'hFF, 3'd2}) begin
                failures++;
                $display("FAIL backpressure_cycle%0d: rdy=%0b vld=%0b sum=%h len=%0d required 0 1 ff 2",
                         c, in_ready, out_valid, out_sum, out_len);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            failures++;
            $display("FAIL backpressure_release: rdy=%0b vld=%0b required 1 0", in_ready, out_valid);
        end
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        checks++;
        if ({out_valid, out_sum, out_len} !== {1'b1, 8'h5A, 3'd1}) begin
            failures++;
            $display("FAIL backpressure_next: vld=%0b sum=%h len=%0d required 1 5a 1", out_valid, out_sum, out_len);
        end
        take_result(0, s, l, e, m);
    endtask

    task automatic test_overflow;
        logic [W-1:0] s; logic [LW-1:0] l; logic e, m;
        for (int i = 0; i < 6; i++) begin fd[i] = 8'h01; fm[i] = 1'b0; end
        drive_frame(6, 0);
        take_result(1, s, l, e, m);
        checks++;
        if ({s, l, e} !== {8'h00, 3'd4, 1'b1}) begin
            failures++;
            $display("FAIL overflow: sum=%h len=%0d err=%0b required 00 4 1", s, l, e);
        end
        fd[0] = 8'h0F; fd[1] = 8'hF0;
        drive_frame(2, 0);
        take_result(0, s, l, e, m);
        checks++;
        if ({s, l, e} !== {8'hFF, 3'd2, 1'b0}) begin
            failures++;
            $display("FAIL overflow_cleared: sum=%h len=%0d err=%0b required ff 2 0", s, l, e);
        end
    endtask

    task automatic test_reset_midframe;
        logic [W-1:0] s; logic [LW-1:0] l; logic e, m;
        fd[0] = 8'h44; fd[1] = 8'h55; fm[0] = 1'b0; fm[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = fd[i]; in_last = 1'b0; mode = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({in_ready, out_valid, out_sum, out_len, out_err} !== {1'b1, 1'b0, 8'h00, 3'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_midframe_state: rdy=%0b vld=%0b sum=%h len=%0d err=%0b required 1 0 00 0 0",
                     in_ready, out_valid, out_sum, out_len, out_err);
        end
        fd[0] = 8'h33; fm[0] = 1'b1;
        drive_frame(1, 0);
        take_result(0, s, l, e, m);
        checks++;
        if ({s, l, e, m} !== {8'h33, 3'd1, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL reset_midframe_frame: sum=%h len=%0d err=%0b mode=%0b required 33 1 1 1", s, l, e, m);
        end
    endtask

    task automatic test_mode_toggle;
        logic [W-1:0] s; logic [LW-1:0] l; logic e, m;
        fd[0] = 8'h11; fd[1] = 8'h22; fm[0] = 1'b0; fm[1] = 1'b1;
        drive_frame(2, 0);
        take_result(0, s, l, e, m);
        checks++;
        if ({s, l, e, m} !== {8'h33, 3'd2, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL mode_toggle: sum=%h len=%0d err=%0b mode=%0b required 33 2 0 0", s, l, e, m);
        end
    endtask

    task automatic test_random;
        logic [W-1:0] s, es; logic [LW-1:0] l, el; logic e, m, ee, em;
        for (int f = 0; f < 40; f++) begin
            int n;
            n = int'($urandom_range(MAXL + 2, 1));
            for (int i = 0; i < n; i++) begin
                fd[i] = W'($urandom);
                fm[i] = 1'($urandom);
            end
            if (fm[0] && $urandom_range(1, 0) == 1) begin
                logic [W-1:0] x;
                x = '0;
                for (int i = 0; i < n - 1; i++) x = x ^ fd[i];
                fd[n-1] = x;
            end
            model(n, es, el, ee, em);
            drive_frame(n, 2);
            take_result(int'($urandom_range(3, 0)), s, l, e, m);
            checks++;
            if ({s, l, e, m} !== {es, el, ee, em}) begin
                failures++;
                $display("FAIL random_frame%0d: sum=%h len=%0d err=%0b mode=%0b required %h %0d %0b %0b",
                         f, s, l, e, m, es, el, ee, em);
            end
        end
    endtask

    initial begin
        test_reset();
        test_generate();
        test_check();
        test_backpressure();
        test_overflow();
        test_reset_midframe();
        test_mode_toggle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
